// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Connects the EX/MEM register to the MEM stage, and the MEM stage to the MEM/WB register.
//   master : the EX/MEM side. It drives the instruction fields and receives the stall and
//            retirement signals.
//   slave  : the MEM stage itself.
//   Upstream signals : in_valid, flush, MemRead, MemWrite, RegWrite, MemtoReg,
//                      AluResult, WriteData, Rd
//   Downstream signals : stall, out_valid, RegWrite_Out, MemtoReg_Out, Dataout_Memory,
//                        AluOut, Rd_out, misalign
interface mem_access_stage_if;
  logic        in_valid;
  logic        flush;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic [63:0] AluResult;
  logic [63:0] WriteData;
  logic [4:0]  Rd;

  logic        stall;
  logic        out_valid;
  logic        RegWrite_Out;
  logic        MemtoReg_Out;
  logic [63:0] Dataout_Memory;
  logic [63:0] AluOut;
  logic [4:0]  Rd_out;
  logic        misalign;

  modport master (
    output in_valid, flush, MemRead, MemWrite, RegWrite, MemtoReg, AluResult, WriteData, Rd,
    input  stall, out_valid, RegWrite_Out, MemtoReg_Out, Dataout_Memory, AluOut, Rd_out, misalign
  );

  modport slave (
    input  in_valid, flush, MemRead, MemWrite, RegWrite, MemtoReg, AluResult, WriteData, Rd,
    output stall, out_valid, RegWrite_Out, MemtoReg_Out, Dataout_Memory, AluOut, Rd_out, misalign
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the 64-bit pipeline. It runs doubleword loads and stores against an internal
//   data memory that takes LAT cycles per access. While an access is in flight it stalls the
//   upstream stages. It retires at most one instruction per out_valid pulse.
//   Ports: clk, reset (asynchronous, active low), bus (mem_access_stage_if.slave).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready to accept; non-memory or misaligned ops retire next cycle
//   BUSY  | aligned memory op in flight; cnt counts down to the access cycle
module mem_access_stage #(
  parameter int DEPTH = 256,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);
  localparam bit MULTI = (LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stall_q, stall_d;

  // Fields of the op held while BUSY
  logic            p_read_q, p_read_d;
  logic            p_write_q, p_write_d;
  logic            p_regwrite_q, p_regwrite_d;
  logic            p_memtoreg_q, p_memtoreg_d;
  logic [AW-1:0]   p_idx_q, p_idx_d;
  logic [63:0]     p_wdata_q, p_wdata_d;
  logic [63:0]     p_alu_q, p_alu_d;
  logic [4:0]      p_rd_q, p_rd_d;

  logic            out_valid_q, out_valid_d;
  logic            regwrite_out_q, regwrite_out_d;
  logic            memtoreg_out_q, memtoreg_out_d;
  logic [63:0]     dout_q, dout_d;
  logic [63:0]     aluout_q, aluout_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            misalign_q, misalign_d;

  logic [63:0]     mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [63:0]     mem_wdata;

  logic            mem_op, mis, accept;
  logic [AW-1:0]   idx;

  assign mem_op = bus.MemRead | bus.MemWrite;
  assign mis    = mem_op & (bus.AluResult[2:0] != 3'b000);
  // Upper address bits are dropped, so addresses wrap modulo DEPTH*8.
  assign idx    = bus.AluResult[AW+2:3];
  assign accept = bus.in_valid & ~bus.flush & (state_q == IDLE);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_d        = stall_q;
    p_read_d       = p_read_q;
    p_write_d      = p_write_q;
    p_regwrite_d   = p_regwrite_q;
    p_memtoreg_d   = p_memtoreg_q;
    p_idx_d        = p_idx_q;
    p_wdata_d      = p_wdata_q;
    p_alu_d        = p_alu_q;
    p_rd_d         = p_rd_q;
    // Retirement flags fall back to a bubble; data outputs hold.
    out_valid_d    = 1'b0;
    regwrite_out_d = 1'b0;
    misalign_d     = 1'b0;
    memtoreg_out_d = memtoreg_out_q;
    dout_d         = dout_q;
    aluout_d       = aluout_q;
    rd_out_d       = rd_out_q;
    mem_we         = 1'b0;
    mem_widx       = idx;
    mem_wdata      = bus.WriteData;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (MULTI && mem_op && !mis) begin
            state_d      = BUSY;
            cnt_d        = CW'(LAT - 1);
            stall_d      = 1'b1;
            p_read_d     = bus.MemRead;
            p_write_d    = bus.MemWrite;
            p_regwrite_d = bus.RegWrite;
            p_memtoreg_d = bus.MemtoReg;
            p_idx_d      = idx;
            p_wdata_d    = bus.WriteData;
            p_alu_d      = bus.AluResult;
            p_rd_d       = bus.Rd;
          end else begin
            // Covers non-memory ops and misaligned ops. When LAT==1 it also covers
            // single-cycle memory ops.
            out_valid_d    = 1'b1;
            regwrite_out_d = bus.RegWrite & ~mis;
            memtoreg_out_d = bus.MemtoReg;
            aluout_d       = bus.AluResult;
            rd_out_d       = bus.Rd;
            misalign_d     = mis;
            dout_d         = (bus.MemRead && !mis) ? mem[idx] : 64'd0;
            mem_we         = bus.MemWrite & ~mis;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
          stall_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d        = IDLE;
            stall_d        = 1'b0;
            out_valid_d    = 1'b1;
            regwrite_out_d = p_regwrite_q;
            memtoreg_out_d = p_memtoreg_q;
            aluout_d       = p_alu_q;
            rd_out_d       = p_rd_q;
            dout_d         = p_read_q ? mem[p_idx_q] : 64'd0;
            mem_we         = p_write_q;
            mem_widx       = p_idx_q;
            mem_wdata      = p_wdata_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_q        <= 1'b0;
      p_read_q       <= 1'b0;
      p_write_q      <= 1'b0;
      p_regwrite_q   <= 1'b0;
      p_memtoreg_q   <= 1'b0;
      p_idx_q        <= '0;
      p_wdata_q      <= '0;
      p_alu_q        <= '0;
      p_rd_q         <= '0;
      out_valid_q    <= 1'b0;
      regwrite_out_q <= 1'b0;
      memtoreg_out_q <= 1'b0;
      dout_q         <= '0;
      aluout_q       <= '0;
      rd_out_q       <= '0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_q        <= stall_d;
      p_read_q       <= p_read_d;
      p_write_q      <= p_write_d;
      p_regwrite_q   <= p_regwrite_d;
      p_memtoreg_q   <= p_memtoreg_d;
      p_idx_q        <= p_idx_d;
      p_wdata_q      <= p_wdata_d;
      p_alu_q        <= p_alu_d;
      p_rd_q         <= p_rd_d;
      out_valid_q    <= out_valid_d;
      regwrite_out_q <= regwrite_out_d;
      memtoreg_out_q <= memtoreg_out_d;
      dout_q         <= dout_d;
      aluout_q       <= aluout_d;
      rd_out_q       <= rd_out_d;
      misalign_q     <= misalign_d;
    end
  end

  // The memory array has no reset. Writes are gated by reset so that a store
  // pending when reset is asserted never lands in the array.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign bus.stall          = stall_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.RegWrite_Out   = regwrite_out_q;
  assign bus.MemtoReg_Out   = memtoreg_out_q;
  assign bus.Dataout_Memory = dout_q;
  assign bus.AluOut         = aluout_q;
  assign bus.Rd_out         = rd_out_q;
  assign bus.misalign       = misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Scoreboard bench for mem_access_stage with LAT=3 and DEPTH=256. Each retirement the
//   bench expects is pushed onto a queue when its stimulus is driven. The entry is popped
//   and compared when out_valid appears. A memory model tracks the stores that should
//   commit, so the bench knows what each load should return.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_stage_if bus();

  mem_access_stage #(.DEPTH(256), .LAT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [63:0] dout;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_mem [256];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [135:0] observed();
    return {bus.RegWrite_Out, bus.MemtoReg_Out, bus.Dataout_Memory, bus.AluOut, bus.Rd_out, bus.misalign};
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 0; bus.flush = 0; bus.MemRead = 0; bus.MemWrite = 0;
    bus.RegWrite = 0; bus.MemtoReg = 0; bus.AluResult = '0; bus.WriteData = '0; bus.Rd = '0;
  endtask

  // Drives one op for a single cycle and computes the retirement it should produce.
  task automatic drive_op(input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
    exp_t e;
    logic mis;
    mis = (mr | mw) && (addr[2:0] != 3'b000);
    bus.in_valid = 1; bus.flush = 0; bus.MemRead = mr; bus.MemWrite = mw;
    bus.RegWrite = rw; bus.MemtoReg = m2r; bus.AluResult = addr; bus.WriteData = wdata; bus.Rd = rd;
    e.rw   = rw & ~mis;
    e.m2r  = m2r;
    e.dout = (mr && !mis) ? model_mem[addr[10:3]] : 64'd0;
    e.alu  = addr;
    e.rd   = rd;
    e.mis  = mis;
    if (mw && !mis) model_mem[addr[10:3]] = wdata;
    sb.push_back(e);
  endtask

  // Issues one op, waits a bounded time for its retirement, and checks the stall
  // window length and the retired fields.
  task automatic run_op(input string name, input logic mr, input logic mw, input logic rw,
                        input logic m2r, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input int exp_stalls);
    int   stalls;
    bit   seen;
    exp_t e;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL %s pre-issue stall: got %b want 0", name, bus.stall);
    end
    drive_op(mr, mw, rw, m2r, addr, wdata, rd);
    @(negedge clk);
    idle_inputs();
    stalls = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.out_valid === 1'b1) seen = 1;
      else begin
        if (bus.stall === 1'b1) stalls++;
        checks++;
        if (bus.RegWrite_Out !== 1'b0) begin
          errors++; $display("FAIL %s bubble RegWrite_Out: got %b want 0", name, bus.RegWrite_Out);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: got no out_valid want out_valid within 10 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (observed() !== e) begin
        errors++; $display("FAIL %s result: got %h want %h", name, observed(), e);
      end
      checks++;
      if (stalls != exp_stalls || bus.stall !== 1'b0) begin
        errors++; $display("FAIL %s stall window: got %0d cycles (stall now %b) want %0d (stall now 0)",
                           name, stalls, bus.stall, exp_stalls);
      end
    end
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.stall, bus.out_valid, observed()} !== '0) begin
        errors++; $display("FAIL reset outputs: got %h want 0", {bus.stall, bus.out_valid, observed()});
      end
      bus.in_valid = 1'($urandom); bus.flush = 1'($urandom); bus.MemRead = 1'($urandom);
      bus.MemWrite = 1'($urandom); bus.RegWrite = 1'($urandom); bus.MemtoReg = 1'($urandom);
      bus.AluResult = {$urandom, $urandom} & ~64'h7; bus.WriteData = {$urandom, $urandom};
      bus.Rd = 5'($urandom);
    end
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.out_valid, observed()} !== '0) begin
      errors++; $display("FAIL reset outputs final: got %h want 0", {bus.stall, bus.out_valid, observed()});
    end
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_alu();
    run_op("alu", 0, 0, 1, 0, 64'h1234, 64'h0, 5'd5, 0);
  endtask

  task automatic test_store_load();
    run_op("store_40", 0, 1, 0, 0, 64'h40, 64'hDEADBEEF, 5'd3, 2);
    run_op("load_40", 1, 0, 1, 1, 64'h40, 64'h0, 5'd7, 2);
    run_op("store_80_seed", 0, 1, 0, 0, 64'h80, 64'h1111, 5'd0, 2);
  endtask

  task automatic test_wrap();
    run_op("store_800", 0, 1, 0, 0, 64'h800, 64'h55, 5'd1, 2);
    run_op("load_0_wrap", 1, 0, 1, 1, 64'h0, 64'h0, 5'd2, 2);
  endtask

  task automatic test_misalign();
    run_op("misalign_load", 1, 0, 1, 1, 64'h44, 64'h0, 5'd9, 0);
    run_op("misalign_store", 0, 1, 0, 0, 64'h83, 64'hBAD, 5'd4, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.stall !== 1'b0) begin
          errors++; $display("FAIL b2b[%0d] handshake: got valid=%b stall=%b want valid=1 stall=0",
                             i - 1, bus.out_valid, bus.stall);
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
          errors++; $display("FAIL b2b[%0d] result: got %h want %h", i - 1, observed(), e);
        end
      end
      if (i < 4) drive_op(0, 0, 1'(i), 1'(i >> 1), {$urandom, $urandom}, 64'h0, 5'(10 + i));
      else idle_inputs();
    end
  endtask

  task automatic test_flush();
    // A flush while IDLE blocks the offered store.
    @(negedge clk);
    bus.in_valid = 1; bus.flush = 1; bus.MemWrite = 1; bus.AluResult = 64'h80; bus.WriteData = 64'h77;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL idle_flush: got valid=%b stall=%b want 0 0", bus.out_valid, bus.stall);
    end
    // A flush while BUSY aborts the store before it writes.
    @(negedge clk);
    bus.in_valid = 1; bus.MemWrite = 1; bus.AluResult = 64'h80; bus.WriteData = 64'h99;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL busy_flush pre stall: got %b want 1", bus.stall);
    end
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL busy_flush: got valid=%b stall=%b want 0 0", bus.out_valid, bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL busy_flush later valid: got %b want 0", bus.out_valid);
    end
    run_op("load_80_after_flush", 1, 0, 1, 1, 64'h80, 64'h0, 5'd8, 2);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.in_valid = 1; bus.MemWrite = 1; bus.AluResult = 64'h80; bus.WriteData = 64'h99;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL reset_abort pre stall: got %b want 1", bus.stall);
    end
    reset = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_abort async: got stall=%b valid=%b want 0 0", bus.stall, bus.out_valid);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_abort after: got valid=%b stall=%b want 0 0", bus.out_valid, bus.stall);
    end
    run_op("load_80_after_reset", 1, 0, 1, 1, 64'h80, 64'h0, 5'd6, 2);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_flush();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard drain: got %0d leftover want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
